// File: rtl/transmission8_rr_sched_pkg.sv
// Shared types and helpers for the 8-source round-robin transmission scheduler.
package transmission8_rr_sched_pkg;

    localparam int N_SRC = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Index offset from base, wrapping naturally modulo 8 through the 3-bit width.
    function automatic logic [SEL_W-1:0] rot_idx(input logic [SEL_W-1:0] base,
                                                 input logic [SEL_W-1:0] off);
        return base + off;
    endfunction

    function automatic logic [N_SRC-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        return {{(N_SRC-1){1'b0}}, 1'b1} << sel;
    endfunction

endpackage

// File: rtl/transmission8_rr_sched_rr_pick8.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod 8.
module rr_pick8
    import transmission8_rr_sched_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] idx_s;

    // Scan from the farthest offset back to ptr so the nearest requester overwrites last.
    always_comb begin
        winner = ptr;
        idx_s  = ptr;
        any    = |req;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx_s  = rot_idx(ptr, SEL_W'(i));
            winner = req[idx_s] ? idx_s : winner;
        end
    end

endmodule

// File: rtl/transmission8_rr_sched.sv
// Round-robin burst scheduler driving the A/B/C selects of the shared 8:1 transmission path.
module transmission8_rr_sched
    import transmission8_rr_sched_pkg::*;
#(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iReq,
    output logic       oA,
    output logic       oB,
    output logic       oC,
    output logic [7:0] oGrant,
    output logic       oBusy,
    output logic       oLast
);

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
    localparam logic             SINGLE_BEAT = (BURST_LEN == 1) ? 1'b1 : 1'b0;

    state_t           state_r, state_s;
    logic [SEL_W-1:0] ptr_r, ptr_s;
    logic [SEL_W-1:0] win_r, win_s;
    logic [SEL_W-1:0] sel_r, sel_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [N_SRC-1:0] grant_r, grant_s;
    logic             busy_r, busy_s;
    logic             last_r, last_s;

    logic [SEL_W-1:0] pick_ptr_s;
    logic [SEL_W-1:0] pick_win_s;
    logic             pick_any_s;

    // At burst end the pointer moves past the current winner; arbitrate from there directly.
    assign pick_ptr_s = (state_r == XFER) ? (win_r + 3'd1) : ptr_r;

    rr_pick8 u_pick (
        .req    (iReq),
        .ptr    (pick_ptr_s),
        .winner (pick_win_s),
        .any    (pick_any_s)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        sel_s   = sel_r;
        cnt_s   = cnt_r;
        grant_s = grant_r;
        busy_s  = busy_r;
        last_s  = last_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    state_s = XFER;
                    win_s   = pick_win_s;
                    sel_s   = pick_win_s;
                    grant_s = sel_to_onehot(pick_win_s);
                    busy_s  = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                    last_s  = SINGLE_BEAT;
                end else begin
                    state_s = IDLE;
                end
            end
            XFER: begin
                if (last_r || !iReq[win_r]) begin
                    ptr_s = win_r + 3'd1;
                    if (pick_any_s) begin
                        state_s = XFER;
                        win_s   = pick_win_s;
                        sel_s   = pick_win_s;
                        grant_s = sel_to_onehot(pick_win_s);
                        busy_s  = 1'b1;
                        cnt_s   = {CNT_W{1'b0}};
                        last_s  = SINGLE_BEAT;
                    end else begin
                        state_s = IDLE;
                        grant_s = {N_SRC{1'b0}};
                        busy_s  = 1'b0;
                        last_s  = 1'b0;
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end else begin
                    cnt_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    last_s = ((cnt_r + {{(CNT_W-1){1'b0}}, 1'b1}) == LAST_BEAT);
                end
            end
            default: begin
                state_s = IDLE;
                grant_s = {N_SRC{1'b0}};
                busy_s  = 1'b0;
                last_s  = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_r <= IDLE;
            ptr_r   <= 3'd0;
            win_r   <= 3'd0;
            sel_r   <= 3'd0;
            cnt_r   <= {CNT_W{1'b0}};
            grant_r <= {N_SRC{1'b0}};
            busy_r  <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            sel_r   <= sel_s;
            cnt_r   <= cnt_s;
            grant_r <= grant_s;
            busy_r  <= busy_s;
            last_r  <= last_s;
        end
    end

    assign oA     = sel_r[2];
    assign oB     = sel_r[1];
    assign oC     = sel_r[0];
    assign oGrant = grant_r;
    assign oBusy  = busy_r;
    assign oLast  = last_r;

endmodule
